// File: rtl/m_adder_pipe.sv
// m_adder_pipe: pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
//
// The operands are split into STAGES slices of SW = WIDTH/STAGES bits. Stage k adds
// slice k and registers the carry into stage k+1. The not-yet-added upper operand bits
// and the already-finished low result bits travel forward with the transaction, so
// every combinational path holds at most one SW-bit add.
//
// Parameters: WIDTH (operand width), STAGES (pipeline depth, divides WIDTH).
// Optional feature macro: ADDER_PIPE_OVF_EN adds the o_ovf_1 signed-overflow output.
//
// Ports:
//   i_clk_1, i_rst_n_1        clock (rising edge), async active-low reset
//   i_valid_1 / o_ready_1     input handshake (o_ready_1 does not depend on i_valid_1)
//   i_sub_1, i_cIn_1          0: A+B+cin, 1: A-B-cin (cin acts as borrow-in)
//   i_adderOperand1_W/2_W     operands A and B
//   o_valid_1 / i_ready_1     output handshake
//   o_adderResult_W, o_cOut_1 result and carry-out (for subtract 1 = no borrow)
//   o_ovf_1                   signed overflow (ADDER_PIPE_OVF_EN only)
module m_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk_1,
  input  logic             i_rst_n_1,
  input  logic             i_valid_1,
  output logic             o_ready_1,
  input  logic             i_sub_1,
  input  logic             i_cIn_1,
  input  logic [WIDTH-1:0] i_adderOperand1_W,
  input  logic [WIDTH-1:0] i_adderOperand2_W,
  output logic             o_valid_1,
  input  logic             i_ready_1,
  output logic [WIDTH-1:0] o_adderResult_W,
  output logic             o_cOut_1
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             o_ovf_1
`endif
);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("m_adder_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  localparam int SW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
  assign adv       = !o_valid_1 || i_ready_1;
  assign o_ready_1 = adv;

  // Subtract as A + ~B + 1; an active borrow-in removes the +1.
  assign b_eff   = i_sub_1 ? ~i_adderOperand2_W : i_adderOperand2_W;
  assign cin_eff = i_sub_1 ? !i_cIn_1 : i_cIn_1;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = (k + 1) * SW;   // result bits finished after this stage
    localparam int AW = WIDTH - RW;     // operand bits still to be added

    logic          v_in;
    logic          c_in;
    logic [SW-1:0] a_s;
    logic [SW-1:0] b_s;
    logic [SW:0]   sum_d;
    logic [RW-1:0] r_d;
    logic          v_q;
    logic          c_q;
    logic [RW-1:0] r_q;

    if (k == 0) begin : g_head
      assign v_in = i_valid_1;
      assign c_in = cin_eff;
      assign a_s  = i_adderOperand1_W[SW-1:0];
      assign b_s  = b_eff[SW-1:0];
      assign r_d  = sum_d[SW-1:0];
    end else begin : g_body
      assign v_in = g_st[k-1].v_q;
      assign c_in = g_st[k-1].c_q;
      assign a_s  = g_st[k-1].g_fwd.a_q[SW-1:0];
      assign b_s  = g_st[k-1].g_fwd.b_q[SW-1:0];
      assign r_d  = {sum_d[SW-1:0], g_st[k-1].r_q};
    end

    assign sum_d = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, c_in};

    always_ff @(posedge i_clk_1 or negedge i_rst_n_1) begin
      if (!i_rst_n_1) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= sum_d[SW];
        r_q <= r_d;
      end
    end

    // Upper operand bits ride along until their slice is reached; the last stage needs none.
    if (k < STAGES - 1) begin : g_fwd
      logic [AW-1:0] a_d;
      logic [AW-1:0] b_d;
      logic [AW-1:0] a_q;
      logic [AW-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = i_adderOperand1_W[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_src_prev
        assign a_d = g_st[k-1].g_fwd.a_q[WIDTH-k*SW-1:SW];
        assign b_d = g_st[k-1].g_fwd.b_q[WIDTH-k*SW-1:SW];
      end

      always_ff @(posedge i_clk_1 or negedge i_rst_n_1) begin
        if (!i_rst_n_1) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    // Operand sign bits are carried to the end, where the result MSB becomes known.
    logic sa_d;
    logic sb_d;
    logic sa_q;
    logic sb_q;

    if (k == 0) begin : g_sgn_in
      assign sa_d = i_adderOperand1_W[WIDTH-1];
      assign sb_d = b_eff[WIDTH-1];
    end else begin : g_sgn_prev
      assign sa_d = g_st[k-1].sa_q;
      assign sb_d = g_st[k-1].sb_q;
    end

    always_ff @(posedge i_clk_1 or negedge i_rst_n_1) begin
      if (!i_rst_n_1) begin
        sa_q <= 1'b0;
        sb_q <= 1'b0;
      end else if (adv) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
      end
    end
`endif
  end

  assign o_valid_1       = g_st[STAGES-1].v_q;
  assign o_adderResult_W = g_st[STAGES-1].r_q;
  assign o_cOut_1        = g_st[STAGES-1].c_q;

`ifdef ADDER_PIPE_OVF_EN
  assign o_ovf_1 = (g_st[STAGES-1].sa_q == g_st[STAGES-1].sb_q) &&
                   (g_st[STAGES-1].r_q[WIDTH-1] != g_st[STAGES-1].sa_q);
`endif

endmodule

// File: tb/tb_m_adder_pipe.sv
module tb_m_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        o_ready;
  logic        sub;
  logic        cin;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        o_valid;
  logic        ready;
  logic [31:0] o_res;
  logic        o_cout;
  logic        o_ovf;

  logic        s1_ready, s1_valid, s1_cout, s1_ovf;
  logic [31:0] s1_res;
  logic        s32_ready, s32_valid, s32_cout, s32_ovf;
  logic [31:0] s32_res;

  m_adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .i_clk_1(clk), .i_rst_n_1(rst_n), .i_valid_1(valid), .o_ready_1(o_ready),
    .i_sub_1(sub), .i_cIn_1(cin), .i_adderOperand1_W(op_a), .i_adderOperand2_W(op_b),
    .o_valid_1(o_valid), .i_ready_1(ready), .o_adderResult_W(o_res), .o_cOut_1(o_cout)
`ifdef ADDER_PIPE_OVF_EN
    , .o_ovf_1(o_ovf)
`endif
  );

  m_adder_pipe #(.WIDTH(32), .STAGES(1)) u_s1 (
    .i_clk_1(clk), .i_rst_n_1(rst_n), .i_valid_1(valid), .o_ready_1(s1_ready),
    .i_sub_1(sub), .i_cIn_1(cin), .i_adderOperand1_W(op_a), .i_adderOperand2_W(op_b),
    .o_valid_1(s1_valid), .i_ready_1(1'b1), .o_adderResult_W(s1_res), .o_cOut_1(s1_cout)
`ifdef ADDER_PIPE_OVF_EN
    , .o_ovf_1(s1_ovf)
`endif
  );

  m_adder_pipe #(.WIDTH(32), .STAGES(32)) u_s32 (
    .i_clk_1(clk), .i_rst_n_1(rst_n), .i_valid_1(valid), .o_ready_1(s32_ready),
    .i_sub_1(sub), .i_cIn_1(cin), .i_adderOperand1_W(op_a), .i_adderOperand2_W(op_b),
    .o_valid_1(s32_valid), .i_ready_1(1'b1), .o_adderResult_W(s32_res), .o_cOut_1(s32_cout)
`ifdef ADDER_PIPE_OVF_EN
    , .o_ovf_1(s32_ovf)
`endif
  );

`ifndef ADDER_PIPE_OVF_EN
  assign o_ovf   = 1'b0;
  assign s1_ovf  = 1'b0;
  assign s32_ovf = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  bit lat_chk  = 1'b0;

  logic [33:0] exp_q[$];
  int          lat_q[$];
  logic        hold_v = 1'b0;
  logic [32:0] hold_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: {ovf, cout, R}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic c);
    logic [31:0] bb;
    logic [32:0] full;
    logic        ov;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, (s ? ~c : c)};
    ov   = (a[31] == bb[31]) && (full[31] != a[31]);
    return {ov, full};
  endfunction

  // Scoreboard: push on accepted input, pop on output transfer, check stall stability.
  always @(negedge clk) begin
    logic [33:0] e;
    int          t;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if ({o_cout, o_res} !== hold_d) begin
          failures++;
          $display("FAIL stall_stable got %h want %h", {o_cout, o_res}, hold_d);
        end
      end
      hold_v = o_valid && !ready;
      hold_d = {o_cout, o_res};
      if (o_valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got %h want none", {o_cout, o_res});
        end else begin
          e = exp_q.pop_front();
          t = lat_q.pop_front();
`ifdef ADDER_PIPE_OVF_EN
          if ({o_ovf, o_cout, o_res} !== e) begin
            failures++;
            $display("FAIL sb_data got %h want %h", {o_ovf, o_cout, o_res}, e);
          end
`else
          if ({o_cout, o_res} !== e[32:0]) begin
            failures++;
            $display("FAIL sb_data got %h want %h", {o_cout, o_res}, e[32:0]);
          end
`endif
          if (lat_chk) begin
            checks++;
            if (cyc - t != 4) begin
              failures++;
              $display("FAIL sb_latency got %0d want 4", cyc - t);
            end
          end
        end
      end
      if (valid && o_ready) begin
        exp_q.push_back(model(op_a, op_b, sub, cin));
        lat_q.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a transaction and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
    int n;
    op_a = a; op_b = b; sub = s; cin = c; valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout got o_ready=0 want 1");
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s got %0d pending want 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    #12;
    checks++;
    if ({o_valid, o_res, o_cout, o_ovf, o_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got v=%b r=%h c=%b o=%b rdy=%b want 0 0 0 0 1",
               o_valid, o_res, o_cout, o_ovf, o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_release got v=%b rdy=%b want v=0 rdy=1", o_valid, o_ready);
    end
  endtask

  task automatic test_add_wrap();
    int n;
    lat_chk = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 50);
    checks++;
    if (!o_valid || cyc - acc_cyc != 4) begin
      failures++;
      $display("FAIL add_wrap_latency got %0d want 4", cyc - acc_cyc);
    end
    checks++;
    if ({o_cout, o_res} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL add_wrap_value got %h want 100000000", {o_cout, o_res});
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_wrap_single got valid=%b want 0", o_valid);
    end
    step(2);
  endtask

  task automatic test_sub();
    lat_chk = 1'b1;
    send(32'h5, 32'h7, 1'b1, 1'b0);
    send(32'h7, 32'h5, 1'b1, 1'b1);
    idle();
    step(8);
    check_empty("sub_drain");
  endtask

  task automatic test_back_to_back();
    int bad;
    lat_chk = 1'b1;
    bad = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          if (o_valid !== ((i >= 4 && i <= 11) ? 1'b1 : 1'b0)) bad++;
        end
      end
    join
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_valid_pattern got %0d wrong cycles want 0", bad);
    end
    step(2);
    check_empty("b2b_drain");
  endtask

  task automatic test_stall();
    int bad;
    lat_chk = 1'b0;
    bad = 0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'(i & 1), 1'($urandom_range(0, 1)));
    fork
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        ready = 1'b1;
      end
    join
    idle();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_ready got %0d bad cycles want 0", bad);
    end
    step(10);
    check_empty("stall_drain");
  endtask

  task automatic test_reset_mid();
    int seen;
    lat_chk = 1'b1;
    send(32'h10, 32'h20, 1'b0, 1'b0);
    send(32'h30, 32'h40, 1'b0, 1'b0);
    send(32'h50, 32'h60, 1'b0, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_res} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid got v=%b r=%h want v=0 r=0", o_valid, o_res);
    end
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_stale got %0d valid cycles want 0", seen);
    end
    step(1);
  endtask

  task automatic test_stage_extremes();
    int t1, t32;
    logic [32:0] r1, r32;
    lat_chk = 1'b1;
    t1 = -1; t32 = -1; r1 = '0; r32 = '0;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 40; i++) begin
      if (s1_valid && t1 < 0) begin t1 = cyc - acc_cyc; r1 = {s1_cout, s1_res}; end
      if (s32_valid && t32 < 0) begin t32 = cyc - acc_cyc; r32 = {s32_cout, s32_res}; end
      @(negedge clk);
    end
    checks++;
    if (t1 != 1 || r1 !== 33'h1_0000_0000) begin
      failures++;
      $display("FAIL stages1 got lat=%0d r=%h want lat=1 r=100000000", t1, r1);
    end
    checks++;
    if (t32 != 32 || r32 !== 33'h1_0000_0000) begin
      failures++;
      $display("FAIL stages32 got lat=%0d r=%h want lat=32 r=100000000", t32, r32);
    end
    step(1);
    check_empty("extremes_drain");
  endtask

`ifdef ADDER_PIPE_OVF_EN
  task automatic test_ovf();
    lat_chk = 1'b1;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0);
    send(32'h1, 32'h1, 1'b0, 1'b0);
    idle();
    step(8);
    check_empty("ovf_drain");
  endtask
`endif

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_stage_extremes();
`ifdef ADDER_PIPE_OVF_EN
    test_ovf();
`endif
    check_empty("final_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
